// File: rtl/demux2_seq.sv
// demux2_seq: sequential 1->2 demultiplexer with serial-to-parallel capture.
//
// A WIDTH-bit word arrives LSB first on 'd'. The first bit comes with 'start'.
// After WIDTH bits have been captured, the word is committed to z0 or z1.
// The choice of register follows the 'sel' value latched with the accepted
// start. A one-cycle valid pulse marks each commit.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - asynchronous active-low reset (0 = reset)
//   start  - transfer start; the same cycle's d is bit 0
//   sel    - destination select (0 -> z0, 1 -> z1), sampled with accepted start
//   d      - serial data bit
//   z0     - channel 0 word register
//   z1     - channel 1 word register
//   valid0 - one-cycle pulse, z0 just updated
//   valid1 - one-cycle pulse, z1 just updated
//   busy   - high whenever a transfer is in flight (state != IDLE)

module demux2_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel,
  input  logic             d,
  output logic [WIDTH-1:0] z0,
  output logic [WIDTH-1:0] z1,
  output logic             valid0,
  output logic             valid1,
  output logic             busy
);

  // The counter must be able to hold WIDTH, so WIDTH=1 still gets one bit.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] z0_d, z1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             valid0_d, valid1_d;
  logic             accept;

  // A new transfer can begin from IDLE or from the COMMIT cycle.
  // Starting from COMMIT keeps busy high across back-to-back words.
  assign accept = start && ((state_q == IDLE) || (state_q == COMMIT));

  assign busy = (state_q != IDLE);

  // Next-state and datapath logic. Every register holds by default.
  // Valid pulses default low, so each one lasts only a single cycle.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    z0_d     = z0;
    z1_d     = z1;
    valid0_d = 1'b0;
    valid1_d = 1'b0;

    case (state_q)
      SHIFT: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt_q == CW'(i)) begin
            shift_d[i] = d;
          end
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        // Only the latched destination changes. The other register keeps its word.
        if (sel_q) begin
          z1_d     = shift_q;
          valid1_d = 1'b1;
        end else begin
          z0_d     = shift_q;
          valid0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
      end
    endcase

    // A start accepted in COMMIT overrides the return to IDLE.
    // It does not affect the commit above, which reads shift_q.
    if (accept) begin
      sel_d      = sel;
      shift_d    = '0;
      shift_d[0] = d;
      cnt_d      = CW'(1);
      state_d    = (WIDTH == 1) ? COMMIT : SHIFT;
    end
  end

  // State and output registers. Reset discards any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      z0      <= '0;
      z1      <= '0;
      valid0  <= 1'b0;
      valid1  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      z0      <= z0_d;
      z1      <= z1_d;
      valid0  <= valid0_d;
      valid1  <= valid1_d;
    end
  end

endmodule

// File: tb/tb_demux2_seq.sv
// tb_demux2_seq: self-checking bench for demux2_seq (WIDTH=4 and WIDTH=1).
// Each transfer is modelled as a word with a start edge s and a destination.
// Under that model, busy is high after edges s..s+W-1.
// The word lands on its destination, with a valid pulse, after edge s+W.

module tb_demux2_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sel = 1'b0;
  logic         d = 1'b0;
  logic [W-1:0] z0, z1;
  logic         valid0, valid1, busy;

  logic         start1 = 1'b0;
  logic         sel1 = 1'b0;
  logic         d1 = 1'b0;
  logic [0:0]   z0_1, z1_1;
  logic         valid0_1, valid1_1, busy_1;

  int pass_cnt = 0;
  int total_cnt = 0;

  // 10-time-unit clock period.
  always #5 clk = ~clk;

  demux2_seq #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .d(d),
    .z0(z0), .z1(z1), .valid0(valid0), .valid1(valid1), .busy(busy)
  );

  demux2_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sel(sel1), .d(d1),
    .z0(z0_1), .z1(z1_1), .valid0(valid0_1), .valid1(valid1_1), .busy(busy_1)
  );

  // Advance past one rising edge. Sampling and driving both happen 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    repeat (2) step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy_held: got %b want 0", busy); else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++; if (z0 !== 4'h0) $display("FAIL rst_z0: got %h want 0", z0); else pass_cnt++;
    total_cnt++; if (z1 !== 4'h0) $display("FAIL rst_z1: got %h want 0", z1); else pass_cnt++;
    total_cnt++; if (valid0 !== 1'b0) $display("FAIL rst_valid0: got %b want 0", valid0); else pass_cnt++;
    total_cnt++; if (valid1 !== 1'b0) $display("FAIL rst_valid1: got %b want 0", valid1); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (busy_1 !== 1'b0) $display("FAIL rst_busy_w1: got %b want 0", busy_1); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    w = 4'hB;
    for (int i = 0; i < W; i++) begin
      start = (i == 0);
      sel = (i == 0);
      d = w[i];
      step();
      total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy[%0d]: got %b want 1", i, busy); else pass_cnt++;
      total_cnt++; if (valid1 !== 1'b0) $display("FAIL basic_early_valid1[%0d]: got %b want 0", i, valid1); else pass_cnt++;
    end
    start = 1'b0;
    step();
    total_cnt++; if (z1 !== 4'hB) $display("FAIL basic_z1: got %h want b", z1); else pass_cnt++;
    total_cnt++; if (valid1 !== 1'b1) $display("FAIL basic_valid1: got %b want 1", valid1); else pass_cnt++;
    total_cnt++; if (valid0 !== 1'b0) $display("FAIL basic_valid0: got %b want 0", valid0); else pass_cnt++;
    total_cnt++; if (z0 !== 4'h0) $display("FAIL basic_z0: got %h want 0", z0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else pass_cnt++;
    step();
    total_cnt++; if (valid1 !== 1'b0) $display("FAIL basic_valid1_pulse: got %b want 0", valid1); else pass_cnt++;
    total_cnt++; if (z1 !== 4'hB) $display("FAIL basic_z1_hold: got %h want b", z1); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1, w2;
    w1 = 4'hB;
    w2 = 4'h6;
    for (int i = 0; i < W; i++) begin
      start = (i == 0);
      sel = 1'b1;
      d = w1[i];
      step();
    end
    // Transfer 1 now sits in COMMIT; the second start is offered in this cycle.
    for (int i = 0; i < W; i++) begin
      start = (i == 0);
      sel = 1'b0;
      d = w2[i];
      step();
      total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy[%0d]: got %b want 1", i, busy); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (valid1 !== 1'b1) $display("FAIL b2b_valid1: got %b want 1", valid1); else pass_cnt++;
        total_cnt++; if (z1 !== 4'hB) $display("FAIL b2b_z1: got %h want b", z1); else pass_cnt++;
      end
      total_cnt++; if (valid0 !== 1'b0) $display("FAIL b2b_early_valid0[%0d]: got %b want 0", i, valid0); else pass_cnt++;
    end
    start = 1'b0;
    step();
    total_cnt++; if (z0 !== 4'h6) $display("FAIL b2b_z0: got %h want 6", z0); else pass_cnt++;
    total_cnt++; if (valid0 !== 1'b1) $display("FAIL b2b_valid0: got %b want 1", valid0); else pass_cnt++;
    total_cnt++; if (valid1 !== 1'b0) $display("FAIL b2b_valid1_end: got %b want 0", valid1); else pass_cnt++;
    total_cnt++; if (z1 !== 4'hB) $display("FAIL b2b_z1_hold: got %h want b", z1); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_ignored_controls();
    logic [W-1:0] w;
    w = 4'h9;
    for (int i = 0; i < W; i++) begin
      start = 1'b1;
      sel = (i == 0) ? 1'b0 : ~sel;
      d = w[i];
      step();
      total_cnt++; if (valid0 !== 1'b0 || valid1 !== 1'b0) $display("FAIL ign_early_valid[%0d]: got %b%b want 00", i, valid1, valid0); else pass_cnt++;
    end
    start = 1'b0;
    step();
    total_cnt++; if (z0 !== 4'h9) $display("FAIL ign_z0: got %h want 9", z0); else pass_cnt++;
    total_cnt++; if (valid0 !== 1'b1) $display("FAIL ign_valid0: got %b want 1", valid0); else pass_cnt++;
    total_cnt++; if (valid1 !== 1'b0) $display("FAIL ign_valid1: got %b want 0", valid1); else pass_cnt++;
    total_cnt++; if (z1 !== 4'hB) $display("FAIL ign_z1: got %h want b", z1); else pass_cnt++;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL ign_no_restart: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    w = 4'h5;
    start = 1'b1; sel = 1'b0; d = 1'b1;
    step();
    start = 1'b0; d = 1'b1;
    step();
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (z0 !== 4'h0) $display("FAIL rmid_z0: got %h want 0", z0); else pass_cnt++;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      total_cnt++; if (valid0 !== 1'b0 || z0 !== 4'h0) $display("FAIL rmid_ghost[%0d]: got v=%b z0=%h want v=0 z0=0", i, valid0, z0); else pass_cnt++;
    end
    for (int i = 0; i < W; i++) begin
      start = (i == 0);
      sel = 1'b0;
      d = w[i];
      step();
    end
    start = 1'b0;
    step();
    total_cnt++; if (z0 !== 4'h5) $display("FAIL rmid_fresh_z0: got %h want 5", z0); else pass_cnt++;
    total_cnt++; if (valid0 !== 1'b1) $display("FAIL rmid_fresh_valid0: got %b want 1", valid0); else pass_cnt++;
    total_cnt++; if (z1 !== 4'h0) $display("FAIL rmid_fresh_z1: got %h want 0", z1); else pass_cnt++;
  endtask

  task automatic test_width1();
    total_cnt++; if (z0_1 !== 1'b0 || z1_1 !== 1'b0) $display("FAIL w1_init: got %b%b want 00", z1_1, z0_1); else pass_cnt++;
    start1 = 1'b1; sel1 = 1'b0; d1 = 1'b1;
    step();
    total_cnt++; if (busy_1 !== 1'b1) $display("FAIL w1_busy: got %b want 1", busy_1); else pass_cnt++;
    total_cnt++; if (valid0_1 !== 1'b0) $display("FAIL w1_early_valid0: got %b want 0", valid0_1); else pass_cnt++;
    // A second word is offered in the COMMIT cycle, aimed at z1.
    start1 = 1'b1; sel1 = 1'b1; d1 = 1'b1;
    step();
    total_cnt++; if (z0_1 !== 1'b1) $display("FAIL w1_z0: got %b want 1", z0_1); else pass_cnt++;
    total_cnt++; if (valid0_1 !== 1'b1) $display("FAIL w1_valid0: got %b want 1", valid0_1); else pass_cnt++;
    total_cnt++; if (valid1_1 !== 1'b0) $display("FAIL w1_valid1_early: got %b want 0", valid1_1); else pass_cnt++;
    start1 = 1'b0;
    step();
    total_cnt++; if (z1_1 !== 1'b1) $display("FAIL w1_z1: got %b want 1", z1_1); else pass_cnt++;
    total_cnt++; if (valid1_1 !== 1'b1 || valid0_1 !== 1'b0) $display("FAIL w1_valid1: got %b%b want 10", valid1_1, valid0_1); else pass_cnt++;
    total_cnt++; if (busy_1 !== 1'b0) $display("FAIL w1_busy_end: got %b want 0", busy_1); else pass_cnt++;
    step();
    total_cnt++; if (valid1_1 !== 1'b0) $display("FAIL w1_pulse: got %b want 0", valid1_1); else pass_cnt++;
  endtask

  task automatic test_random();
    localparam int NT = 12;
    int           t_start[NT];
    logic         t_sel[NT];
    logic [W-1:0] t_word[NT];
    logic [W-1:0] exp_z0, exp_z1;
    logic         exp_v0, exp_v1, exp_busy;
    int           last_edge, k;

    rst = 1'b0;
    start = 1'b0;
    step();
    rst = 1'b1;
    exp_z0 = '0;
    exp_z1 = '0;

    // Gap 0 means the next start lands on the previous COMMIT edge.
    t_start[0] = 1;
    for (int i = 0; i < NT; i++) begin
      if (i > 0) t_start[i] = t_start[i-1] + W + int'($urandom_range(0, 3));
      t_sel[i] = 1'($urandom_range(0, 1));
      t_word[i] = W'($urandom_range(0, (1 << W) - 1));
    end
    last_edge = t_start[NT-1] + W + 2;

    for (int n = 0; n <= last_edge; n++) begin
      k = -1;
      for (int i = 0; i < NT; i++) begin
        if (t_start[i] <= n && n < t_start[i] + W) k = i;
      end
      if (k >= 0 && n == t_start[k]) begin
        start = 1'b1; sel = t_sel[k]; d = t_word[k][0];
      end else if (k >= 0) begin
        start = 1'($urandom_range(0, 1)); sel = 1'($urandom_range(0, 1)); d = t_word[k][n - t_start[k]];
      end else begin
        start = 1'b0; sel = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
      end
      step();

      exp_busy = (k >= 0);
      exp_v0 = 1'b0;
      exp_v1 = 1'b0;
      for (int i = 0; i < NT; i++) begin
        if (t_start[i] + W == n) begin
          if (t_sel[i]) begin exp_v1 = 1'b1; exp_z1 = t_word[i]; end
          else begin exp_v0 = 1'b1; exp_z0 = t_word[i]; end
        end
      end
      total_cnt++; if (busy !== exp_busy) $display("FAIL rnd_busy@%0d: got %b want %b", n, busy, exp_busy); else pass_cnt++;
      total_cnt++; if (valid0 !== exp_v0 || valid1 !== exp_v1) $display("FAIL rnd_valid@%0d: got %b%b want %b%b", n, valid1, valid0, exp_v1, exp_v0); else pass_cnt++;
      total_cnt++; if (z0 !== exp_z0 || z1 !== exp_z1) $display("FAIL rnd_z@%0d: got z0=%h z1=%h want z0=%h z1=%h", n, z0, z1, exp_z0, exp_z1); else pass_cnt++;
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_controls();
    test_reset_mid();
    test_width1();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
